// File: rtl/axi_mem_master_bridge.sv
// Single-beat core memory request to AXI master bridge.
// One transaction outstanding; response held until the core takes it.
package axi_mem_pkg;
  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct packed {
    logic [AW-1:0] araddr;
    logic [2:0]    arport;
    logic          arvalid;
    logic          rready;
  } axi_mr_t;

  typedef struct packed {
    logic [AW-1:0]   awaddr;
    logic [2:0]      awport;
    logic            awvalid;
    logic [DW-1:0]   wdata;
    logic            wvalid;
    logic [DW/8-1:0] wstrb;
    logic            bready;
  } axi_mw_t;

  typedef struct packed {
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
  } axi_sr_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
  } axi_sw_t;
endpackage

module axi_mem_master_bridge
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = AW,
  parameter int DATA_WIDTH = DW
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2:0]              req_port,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_code,
  output logic                    resp_err,
  output axi_mr_t                 Mr,
  output axi_mw_t                 Mw,
  input  axi_sr_t                 Sr,
  input  axi_sw_t                 Sw
);

  typedef enum logic [2:0] {
    IDLE, AR, R, AWW, B, RESP
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              port_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              code_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_ok;
  logic                    w_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    aw_ok   = aw_done | Sw.awready;
    w_ok    = w_done | Sw.wready;
    unique case (state)
      IDLE: if (req_valid) state_n = req_we ? AWW : AR;
      AR:   if (Sr.arready) state_n = R;
      R:    if (Sr.rvalid) state_n = RESP;
      AWW:  if (aw_ok && w_ok) state_n = B;
      B:    if (Sw.bvalid) state_n = RESP;
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      port_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      code_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        port_q  <= req_port;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      // each write channel retires on its own handshake
      if (state == AWW) begin
        if (Sw.awready) aw_done <= 1'b1;
        if (Sw.wready)  w_done  <= 1'b1;
      end
      if (state == R && Sr.rvalid) begin
        rdata_q <= Sr.rdata;
        code_q  <= Sr.rresp;
      end
      if (state == B && Sw.bvalid) begin
        rdata_q <= '0;
        code_q  <= Sw.bresp;
      end
    end
  end

  always_comb begin
    Mr         = '0;
    Mr.araddr  = addr_q;
    Mr.arport  = port_q;
    Mr.arvalid = (state == AR);
    Mr.rready  = (state == R);
    Mw         = '0;
    Mw.awaddr  = addr_q;
    Mw.awport  = port_q;
    Mw.awvalid = (state == AWW) && !aw_done;
    Mw.wdata   = wdata_q;
    Mw.wstrb   = wstrb_q;
    Mw.wvalid  = (state == AWW) && !w_done;
    Mw.bready  = (state == B);
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_code  = code_q;
  assign resp_err   = |code_q;

endmodule

// File: tb/tb_axi_mem_master_bridge.sv
// Bench for axi_mem_master_bridge: vector table, random traffic
// against a timing/response model, and reset/back-to-back sequences.
module tb_axi_mem_master_bridge;
  import axi_mem_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [2:0]  req_port;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_code;
  logic        resp_err;
  axi_mr_t     Mr;
  axi_mw_t     Mw;
  axi_sr_t     Sr;
  axi_sw_t     Sw;

  int n_cmp = 0;
  int n_bad = 0;

  axi_mem_master_bridge dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_port(req_port), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_code(resp_code),
    .resp_err(resp_err),
    .Mr(Mr), .Mw(Mw), .Sr(Sr), .Sw(Sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [2:0]  port;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [63:0] rdata;
    logic [1:0]  rresp, bresp;
    int          hold;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_code;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic we, input logic [63:0] addr,
      input logic [2:0] port, input logic [63:0] wdata,
      input logic [7:0] wstrb, input int ar, input int r,
      input int aw, input int w, input int b,
      input logic [63:0] rdata, input logic [1:0] rresp,
      input logic [1:0] bresp, input int hold,
      input logic [63:0] erd, input logic [1:0] ecode,
      input logic eerr, input int elat);
    vec_t v;
    v.we = we; v.addr = addr; v.port = port;
    v.wdata = wdata; v.wstrb = wstrb;
    v.ar_dly = ar; v.r_dly = r; v.aw_dly = aw;
    v.w_dly = w; v.b_dly = b;
    v.rdata = rdata; v.rresp = rresp; v.bresp = bresp;
    v.hold = hold;
    v.exp_rdata = erd; v.exp_code = ecode;
    v.exp_err = eerr; v.exp_lat = elat;
    return v;
  endfunction

  // Response model: what the core should see and when.
  function automatic vec_t model(input vec_t t);
    vec_t v = t;
    int wmax = (t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly;
    v.exp_rdata = t.we ? 64'd0 : t.rdata;
    v.exp_code  = t.we ? t.bresp : t.rresp;
    v.exp_err   = (v.exp_code != 2'b00);
    v.exp_lat   = t.we ? 3 + wmax + t.b_dly
                       : 3 + t.ar_dly + t.r_dly;
    return v;
  endfunction

  task automatic slave_idle();
    Sr = '0;
    Sw = '0;
  endtask

  task automatic run_txn(input vec_t t, input string tag);
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    bit ar_done = 0, aw_done = 0, w_done = 0;
    bit r_fin = 0, b_fin = 0, fin = 0;
    int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
    int n_rv = 0, n_rr = 0, bad_addr = 0, bad_hold = 0;
    int proto = 0, lat = -1;
    logic [63:0] rd0 = '0;
    logic [1:0]  c0 = '0;
    logic        e0 = 1'b0;
    logic        rv, bv;
    @(negedge clk);
    chk({tag, " idle_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_we    = t.we;
    req_addr  = t.addr;
    req_port  = t.port;
    req_wdata = t.wdata;
    req_wstrb = t.wstrb;
    for (int k = 1; k <= 200 && !fin; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      n_rr += int'(req_ready);
      if (Mr.arvalid) begin
        n_ar++;
        if (Mr.araddr !== t.addr || Mr.arport !== t.port)
          bad_addr++;
      end
      if (Mw.awvalid) begin
        n_aw++;
        if (Mw.awaddr !== t.addr || Mw.awport !== t.port)
          bad_addr++;
      end
      if (Mw.wvalid) begin
        n_w++;
        if (Mw.wdata !== t.wdata || Mw.wstrb !== t.wstrb)
          bad_addr++;
      end
      n_r += int'(Mr.rready);
      n_b += int'(Mw.bready);
      if (Mw.bready && (Mw.awvalid || Mw.wvalid)) proto++;
      if (t.we ? (Mr.arvalid || Mr.rready)
               : (Mw.awvalid || Mw.wvalid || Mw.bready))
        proto++;
      if (resp_valid) begin
        if (n_rv == 0) begin
          lat = k; rd0 = resp_rdata;
          c0 = resp_code; e0 = resp_err;
        end else if (resp_rdata !== rd0 || resp_code !== c0)
          bad_hold++;
        n_rv++;
      end
      // read slave
      rv = ar_done && !r_fin && r_c >= t.r_dly;
      if (ar_done) r_c++;
      if (rv && Mr.rready) r_fin = 1;
      Sr.rvalid  = rv;
      Sr.rdata   = rv ? t.rdata : {$urandom, $urandom};
      Sr.rresp   = rv ? t.rresp : 2'($urandom);
      Sr.arready = Mr.arvalid && ar_c >= t.ar_dly;
      if (Mr.arvalid) ar_c++;
      if (Mr.arvalid && Sr.arready) ar_done = 1;
      // write slave
      bv = aw_done && w_done && !b_fin && b_c >= t.b_dly;
      if (aw_done && w_done) b_c++;
      if (bv && Mw.bready) b_fin = 1;
      Sw.bvalid  = bv;
      Sw.bresp   = bv ? t.bresp : 2'($urandom);
      Sw.awready = Mw.awvalid && aw_c >= t.aw_dly;
      Sw.wready  = Mw.wvalid && w_c >= t.w_dly;
      if (Mw.awvalid) aw_c++;
      if (Mw.wvalid) w_c++;
      if (Mw.awvalid && Sw.awready) aw_done = 1;
      if (Mw.wvalid && Sw.wready) w_done = 1;
      resp_ready = resp_valid && (n_rv - 1) >= t.hold;
      if (resp_valid && resp_ready) fin = 1;
    end
    chk({tag, " completed"}, fin, 1);
    @(negedge clk);
    slave_idle();
    resp_ready = 1'b0;
    chk({tag, " latency"}, lat, t.exp_lat);
    chk({tag, " rdata"}, rd0, t.exp_rdata);
    chk({tag, " code"}, c0, t.exp_code);
    chk({tag, " err"}, e0, t.exp_err);
    chk({tag, " ar_cycles"}, n_ar, t.we ? 0 : t.ar_dly + 1);
    chk({tag, " r_cycles"}, n_r, t.we ? 0 : t.r_dly + 1);
    chk({tag, " aw_cycles"}, n_aw, t.we ? t.aw_dly + 1 : 0);
    chk({tag, " w_cycles"}, n_w, t.we ? t.w_dly + 1 : 0);
    chk({tag, " b_cycles"}, n_b, t.we ? t.b_dly + 1 : 0);
    chk({tag, " resp_cycles"}, n_rv, t.hold + 1);
    chk({tag, " payload_stable"}, bad_addr, 0);
    chk({tag, " resp_stable"}, bad_hold, 0);
    chk({tag, " protocol"}, proto, 0);
    chk({tag, " busy_not_ready"}, n_rr, 0);
    chk({tag, " ready_after"}, req_ready, 1);
  endtask

  vec_t tbl[6];
  vec_t rv_t;

  initial begin
    int acc2, r1_k, r2_k;
    logic [2:0]  arp, awp;
    logic [63:0] r1_d, r2_d;
    logic [1:0]  r2_c;
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_port = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    slave_idle();

    @(negedge clk);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst valids", {Mr.arvalid, Mr.rready, Mw.awvalid,
                       Mw.wvalid, Mw.bready}, 0);
    chk("rst rdata", resp_rdata, 0);
    chk("rst code", resp_code, 0);
    chk("rst req_ready", req_ready, 1);
    rstn = 1'b1;

    tbl[0] = mk(0, 64'h1000_0040, 3'd1, 64'h0, 8'h00,
                0, 0, 0, 0, 0, 64'hDEAD_BEEF_0123_4567,
                2'b00, 2'b00, 0,
                64'hDEAD_BEEF_0123_4567, 2'b00, 0, 3);
    tbl[1] = mk(1, 64'h8000_0010, 3'd3, 64'hCAFE_F00D_1234_5678,
                8'h0F, 0, 0, 3, 0, 0, 64'h0,
                2'b00, 2'b00, 0, 64'h0, 2'b00, 0, 6);
    tbl[2] = mk(0, 64'h2000_0008, 3'd0, 64'h0, 8'h00,
                0, 0, 0, 0, 0, 64'h1111_2222_3333_4444,
                2'b10, 2'b00, 0,
                64'h1111_2222_3333_4444, 2'b10, 1, 3);
    tbl[3] = mk(1, 64'h3000_0000, 3'd7, 64'h5555_AAAA_5555_AAAA,
                8'hFF, 0, 0, 0, 0, 0, 64'h0,
                2'b00, 2'b11, 0, 64'h0, 2'b11, 1, 3);
    tbl[4] = mk(0, 64'h4000_0100, 3'd2, 64'h0, 8'h00,
                1, 2, 0, 0, 0, 64'h0BAD_C0DE_FACE_0001,
                2'b00, 2'b00, 5,
                64'h0BAD_C0DE_FACE_0001, 2'b00, 0, 6);
    tbl[5] = mk(1, 64'h5000_0020, 3'd4, 64'h0123_4567_89AB_CDEF,
                8'hA5, 0, 0, 0, 2, 1, 64'h0,
                2'b00, 2'b01, 2, 64'h0, 2'b01, 1, 6);
    for (int i = 0; i < 6; i++)
      run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv_t.we     = 1'($urandom);
      rv_t.addr   = {$urandom, $urandom};
      rv_t.port   = 3'($urandom_range(0, 7));
      rv_t.wdata  = {$urandom, $urandom};
      rv_t.wstrb  = 8'($urandom);
      rv_t.ar_dly = $urandom_range(0, 3);
      rv_t.r_dly  = $urandom_range(0, 3);
      rv_t.aw_dly = $urandom_range(0, 3);
      rv_t.w_dly  = $urandom_range(0, 3);
      rv_t.b_dly  = $urandom_range(0, 3);
      rv_t.rdata  = {$urandom, $urandom};
      rv_t.rresp  = 2'($urandom);
      rv_t.bresp  = 2'($urandom);
      rv_t.hold   = $urandom_range(0, 3);
      run_txn(model(rv_t), $sformatf("rnd%0d", i));
    end

    // back-to-back: read then write with req_valid held high
    Sr.arready = 1'b1; Sr.rvalid = 1'b1;
    Sr.rdata = 64'h7777_6666_5555_4444; Sr.rresp = 2'b00;
    Sw.awready = 1'b1; Sw.wready = 1'b1;
    Sw.bvalid = 1'b1; Sw.bresp = 2'b01;
    resp_ready = 1'b1;
    acc2 = -1; r1_k = -1; r2_k = -1;
    arp = '0; awp = '0; r1_d = '0; r2_d = '1; r2_c = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0;
    req_addr = 64'hA000_0000; req_port = 3'd5;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_we = 1'b1; req_addr = 64'hB000_0000;
        req_port = 3'd2; req_wdata = 64'h1; req_wstrb = 8'h01;
      end
      if (acc2 >= 0 && k == acc2 + 1) req_valid = 1'b0;
      if (req_ready && acc2 < 0) acc2 = k;
      if (Mr.arvalid) arp = Mr.arport;
      if (Mw.awvalid) awp = Mw.awport;
      if (resp_valid && r1_k < 0) begin
        r1_k = k; r1_d = resp_rdata;
      end else if (resp_valid && r2_k < 0) begin
        r2_k = k; r2_d = resp_rdata; r2_c = resp_code;
      end
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    slave_idle();
    chk("b2b second_accept", acc2, 4);
    chk("b2b arport", arp, 3'd5);
    chk("b2b awport", awp, 3'd2);
    chk("b2b read_resp_cycle", r1_k, 3);
    chk("b2b read_rdata", r1_d, 64'h7777_6666_5555_4444);
    chk("b2b write_resp_cycle", r2_k, 7);
    chk("b2b write_rdata", r2_d, 0);
    chk("b2b write_code", r2_c, 2'b01);

    // asynchronous reset while the write channels are pending
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 64'hC000_0000; req_port = 3'd6;
    @(negedge clk);
    req_valid = 1'b0;
    chk("arst awvalid_before", Mw.awvalid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst awvalid", Mw.awvalid, 0);
    chk("arst wvalid", Mw.wvalid, 0);
    chk("arst resp_valid", resp_valid, 0);
    chk("arst code", resp_code, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst req_ready", req_ready, 1);
    chk("arst bready", Mw.bready, 0);
    run_txn(tbl[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
